// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Holds the fetch PC, advances it sequentially, and loads it from one of
// NUM_REDIRECT prioritised redirect channels (channel 0 highest priority).
// A redirect arriving while the stage is stalled is kept in a one-entry
// pending buffer until the stage is enabled again.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int unsigned     INC          = 4,
    parameter int unsigned     NUM_REDIRECT = 3,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_REDIRECT-1:0]      redirect_valid,
    input  logic [NUM_REDIRECT*XLEN-1:0] redirect_target,
    output logic [XLEN-1:0]              PC,
    output logic                         redirected,
    output logic                         misaligned,
    output logic                         pending
);

    localparam int unsigned     IDXW       = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    // Ones in the low ALIGN_BITS positions.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

    // Force the low alignment bits of a target to zero.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
        return t & ~ALIGN_MASK;
    endfunction

    // True when a target has any nonzero low alignment bit.
    function automatic logic low_bits_set(input logic [XLEN-1:0] t);
        return |(t & ALIGN_MASK);
    endfunction

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [IDXW-1:0] pend_idx_q, pend_idx_d;
    logic            redirected_q, redirected_d;
    logic            misaligned_q, misaligned_d;

    logic            live_valid_s;
    logic [IDXW-1:0] live_idx_s;
    logic [XLEN-1:0] live_tgt_s;
    logic            cand_valid_s;
    logic [XLEN-1:0] cand_tgt_s;
    logic            live_beats_pend_s;

    // Live winner: lowest-index channel requesting a redirect this cycle.
    always_comb begin
        live_valid_s = 1'b0;
        live_idx_s   = {IDXW{1'b0}};
        live_tgt_s   = {XLEN{1'b0}};
        for (int i = int'(NUM_REDIRECT) - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                live_valid_s = 1'b1;
                live_idx_s   = IDXW'(i);
                live_tgt_s   = redirect_target[i*XLEN +: XLEN];
            end else begin
                live_valid_s = live_valid_s;
            end
        end
    end

    // Choose between live winner and pending entry; live wins ties on index.
    always_comb begin
        cand_valid_s      = 1'b0;
        cand_tgt_s        = {XLEN{1'b0}};
        // Strictly-lower test used when deciding whether to overwrite pending.
        live_beats_pend_s = live_valid_s && (!pend_q || (live_idx_s < pend_idx_q));
        if (live_valid_s && (!pend_q || (live_idx_s <= pend_idx_q))) begin
            cand_valid_s = 1'b1;
            cand_tgt_s   = live_tgt_s;
        end else if (pend_q) begin
            cand_valid_s = 1'b1;
            cand_tgt_s   = pend_tgt_q;
        end else begin
            cand_valid_s = 1'b0;
        end
    end

    // Next-state logic for PC, pending buffer and one-cycle flags.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        pend_idx_d   = pend_idx_q;
        redirected_d = 1'b0;
        misaligned_d = 1'b0;
        if (en) begin
            pend_d = 1'b0;
            if (cand_valid_s) begin
                pc_d         = align_target(cand_tgt_s);
                redirected_d = 1'b1;
                misaligned_d = low_bits_set(cand_tgt_s);
            end else begin
                pc_d = pc_q + INC_V;
            end
        end else begin
            // Stalled: PC holds; a strictly better live redirect replaces pending.
            if (live_beats_pend_s) begin
                pend_d     = 1'b1;
                pend_tgt_d = live_tgt_s;
                pend_idx_d = live_idx_s;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            pend_q       <= 1'b0;
            pend_tgt_q   <= {XLEN{1'b0}};
            pend_idx_q   <= {IDXW{1'b0}};
            redirected_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_idx_q   <= pend_idx_d;
            redirected_q <= redirected_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign PC         = pc_q;
    assign redirected = redirected_q;
    assign misaligned = misaligned_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch PC and pending buffer.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  redirect_valid;
    logic [95:0] redirect_target;
    logic [31:0] PC;
    logic        redirected;
    logic        misaligned;
    logic        pending;

    int total;
    int bad;

    // Behavioural model state.
    logic [31:0] m_pc;
    bit          m_pend;
    int          m_pidx;
    logic [31:0] m_ptgt;
    bit          m_red;
    bit          m_mis;

    pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(RV),
        .INC(4),
        .NUM_REDIRECT(3),
        .ALIGN_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .PC(PC),
        .redirected(redirected),
        .misaligned(misaligned),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc   = RV;
        m_pend = 1'b0;
        m_pidx = 0;
        m_ptgt = 32'h0;
        m_red  = 1'b0;
        m_mis  = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model on the edge, sample at edge+1.
    task automatic drive_step(input logic e, input logic [2:0] v,
                              input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
        logic [31:0] tg [3];
        int          live;
        logic [31:0] use_t;
        bit          take;
        tg[0] = t0; tg[1] = t1; tg[2] = t2;
        en              = e;
        redirect_valid  = v;
        redirect_target = {t2, t1, t0};
        @(posedge clk);
        live = -1;
        for (int i = 0; i < 3; i++)
            if (v[i] && live < 0) live = i;
        if (e) begin
            take  = 1'b1;
            use_t = 32'h0;
            if (live >= 0 && (!m_pend || live <= m_pidx)) use_t = tg[live];
            else if (m_pend) use_t = m_ptgt;
            else take = 1'b0;
            if (take) begin
                m_pc  = {use_t[31:2], 2'b00};
                m_red = 1'b1;
                m_mis = (use_t[1:0] != 2'b00);
            end else begin
                m_pc  = m_pc + 32'd4;
                m_red = 1'b0;
                m_mis = 1'b0;
            end
            m_pend = 1'b0;
        end else begin
            m_red = 1'b0;
            m_mis = 1'b0;
            if (live >= 0 && (!m_pend || live < m_pidx)) begin
                m_pend = 1'b1;
                m_pidx = live;
                m_ptgt = tg[live];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1; redirect_valid = 3'b000; redirect_target = 96'h0;
        model_reset();
        #22;
        total++; if (PC !== 32'h1000) begin bad++; $display("FAIL reset_pc got=%h want=%h", PC, 32'h1000); end
        total++; if ({redirected, misaligned, pending} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {redirected, misaligned, pending}); end
        reset = 1'b0;
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (PC !== 32'h1004) begin bad++; $display("FAIL step1_pc got=%h want=%h", PC, 32'h1004); end
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (PC !== 32'h1008) begin bad++; $display("FAIL step2_pc got=%h want=%h", PC, 32'h1008); end
        total++; if ({redirected, misaligned, pending} !== 3'b000) begin bad++; $display("FAIL step_flags got=%b want=000", {redirected, misaligned, pending}); end
    endtask

    task automatic test_priority();
        drive_step(1'b1, 3'b001, 32'h2000, 32'h0, 32'h0);
        total++; if (PC !== 32'h2000) begin bad++; $display("FAIL prio_setup got=%h want=%h", PC, 32'h2000); end
        drive_step(1'b1, 3'b110, 32'h0, 32'h3000, 32'h4000);
        total++; if (PC !== 32'h3000) begin bad++; $display("FAIL prio_pc got=%h want=%h", PC, 32'h3000); end
        total++; if (redirected !== 1'b1) begin bad++; $display("FAIL prio_redirected got=%b want=1", redirected); end
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (PC !== 32'h3004) begin bad++; $display("FAIL prio_next got=%h want=%h", PC, 32'h3004); end
        total++; if (redirected !== 1'b0) begin bad++; $display("FAIL prio_redirected_drop got=%b want=0", redirected); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = PC;
        drive_step(1'b0, 3'b100, 32'h0, 32'h0, 32'h4000);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL stall_pending got=%b want=1", pending); end
        total++; if (PC !== held) begin bad++; $display("FAIL stall_hold got=%h want=%h", PC, held); end
        drive_step(1'b0, 3'b010, 32'h0, 32'h3000, 32'h0);
        drive_step(1'b0, 3'b100, 32'h0, 32'h0, 32'h5000);
        total++; if (PC !== held) begin bad++; $display("FAIL stall_hold2 got=%h want=%h", PC, held); end
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (PC !== 32'h3000) begin bad++; $display("FAIL stall_release got=%h want=%h", PC, 32'h3000); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL stall_pending_clr got=%b want=0", pending); end
        total++; if (redirected !== 1'b1) begin bad++; $display("FAIL stall_redirected got=%b want=1", redirected); end
    endtask

    task automatic test_live_vs_pending();
        drive_step(1'b0, 3'b010, 32'h0, 32'h3000, 32'h0);
        drive_step(1'b1, 3'b001, 32'h100, 32'h0, 32'h0);
        total++; if (PC !== 32'h100) begin bad++; $display("FAIL live_ch0 got=%h want=%h", PC, 32'h100); end
        drive_step(1'b0, 3'b010, 32'h0, 32'h3000, 32'h0);
        drive_step(1'b1, 3'b010, 32'h0, 32'h200, 32'h0);
        total++; if (PC !== 32'h200) begin bad++; $display("FAIL live_equal got=%h want=%h", PC, 32'h200); end
        drive_step(1'b0, 3'b001, 32'h700, 32'h0, 32'h0);
        drive_step(1'b1, 3'b100, 32'h0, 32'h0, 32'h900);
        total++; if (PC !== 32'h700) begin bad++; $display("FAIL pend_beats_live got=%h want=%h", PC, 32'h700); end
    endtask

    task automatic test_wrap_misalign();
        drive_step(1'b1, 3'b001, 32'hFFFF_FFFC, 32'h0, 32'h0);
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL wrap got=%h want=%h", PC, 32'h0); end
        total++; if ({redirected, misaligned} !== 2'b00) begin bad++; $display("FAIL wrap_flags got=%b want=00", {redirected, misaligned}); end
        drive_step(1'b1, 3'b001, 32'h1002, 32'h0, 32'h0);
        total++; if (PC !== 32'h1000) begin bad++; $display("FAIL misalign_pc got=%h want=%h", PC, 32'h1000); end
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL misalign_flag got=%b want=1", misaligned); end
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL misalign_drop got=%b want=0", misaligned); end
    endtask

    task automatic test_reset_async();
        drive_step(1'b0, 3'b010, 32'h0, 32'h3000, 32'h0);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL async_pre_pending got=%b want=1", pending); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++; if (PC !== RV) begin bad++; $display("FAIL async_pc got=%h want=%h", PC, RV); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL async_pending got=%b want=0", pending); end
        #1;
        reset = 1'b0;
        drive_step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
        total++; if (PC !== 32'h1004) begin bad++; $display("FAIL async_release got=%h want=%h", PC, 32'h1004); end
        total++; if (redirected !== 1'b0) begin bad++; $display("FAIL async_no_redirect got=%b want=0", redirected); end
    endtask

    task automatic test_random();
        logic        e;
        logic [2:0]  v;
        logic [31:0] t0, t1, t2;
        for (int n = 0; n < 400; n++) begin
            e  = ($urandom_range(0, 9) < 6);
            v  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            t0 = $urandom; t1 = $urandom; t2 = $urandom;
            if (n % 50 == 7) t0 = 32'hFFFF_FFF8;
            drive_step(e, v, t0, t1, t2);
            total++; if (PC !== m_pc) begin bad++; $display("FAIL rand_pc cyc=%0d got=%h want=%h", n, PC, m_pc); end
            total++; if (pending !== m_pend) begin bad++; $display("FAIL rand_pending cyc=%0d got=%b want=%b", n, pending, m_pend); end
            total++; if (redirected !== m_red) begin bad++; $display("FAIL rand_redirected cyc=%0d got=%b want=%b", n, redirected, m_red); end
            total++; if (misaligned !== m_mis) begin bad++; $display("FAIL rand_misaligned cyc=%0d got=%b want=%b", n, misaligned, m_mis); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_priority();
        test_stall();
        test_live_vs_pending();
        test_wrap_misalign();
        test_reset_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
